// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite response codes and APB-to-AXI bridge state encoding.
// Imported by the interface, the bridge top and the bench.
package axi_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4,
        DONE    = 3'd5
    } apb_axi_state_t;

    function automatic logic resp_is_err(input axi_resp_t r);
        return (r == SLVERR) || (r == DECERR);
    endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI-Lite bundle (aw/w/b/ar/r). Every channel uses strict valid/ready: a beat transfers on a
// rising clock edge where valid and ready are both high; valid, once raised, holds until that beat.
interface axi_lite_if
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W = 32
) ();

    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              wvalid;
    logic              wready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              bvalid;
    logic              bready;
    axi_resp_t         bresp;
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              rvalid;
    logic              rready;
    logic [31:0]       rdata;
    axi_resp_t         rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

endinterface

// File: rtl/apb_axi_timer.sv
// Response timeout counter: cleared while idle, counts busy cycles, flags the TIMEOUT_CYC-th one.
module apb_axi_timer #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_busy,
    output logic o_expired
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] r_cnt;

    assign o_expired = i_busy && (r_cnt == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_busy && !o_expired) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/apb_axi_bridge.sv
// APB completer to AXI-Lite initiator, one transaction in flight.
// Optional response timeout enabled by defining APB_AXI_BRIDGE_TIMEOUT_EN.
module apb_axi_bridge
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [31:0]       PWDATA,
    input  logic [3:0]        PSTRB,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    axi_lite_if.master        m_axi,
    output logic [2:0]        state
);

    apb_axi_state_t    r_state;
    apb_axi_state_t    w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_strb;
    logic              r_write;
    logic              r_aw_done;
    logic              r_w_done;
    logic              r_abort;
    logic              r_slverr;
    logic [31:0]       r_rdata;
    logic              w_awvalid;
    logic              w_wvalid;
    logic              w_bready;
    logic              w_arvalid;
    logic              w_rready;
    logic              w_pready;
    logic              w_timeout;

`ifdef APB_AXI_BRIDGE_TIMEOUT_EN
    apb_axi_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk       (aclk),
        .rst       (areset),
        .i_clear   (r_state == IDLE),
        .i_busy    ((r_state != IDLE) && (r_state != DONE)),
        .o_expired (w_timeout)
    );
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = (TIMEOUT_CYC != 0);
    assign w_timeout            = 1'b0;
`endif

    // On timeout every valid/ready is dropped in the expiring cycle so no late beat slips through.
    always_comb begin
        w_next    = r_state;
        w_awvalid = 1'b0;
        w_wvalid  = 1'b0;
        w_bready  = 1'b0;
        w_arvalid = 1'b0;
        w_rready  = 1'b0;
        w_pready  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    w_next = PWRITE ? WR_ADDR : RD_ADDR;
                end
            end
            WR_ADDR: begin
                w_awvalid = !r_aw_done && !w_timeout;
                w_wvalid  = !r_w_done && !w_timeout;
                if (w_timeout) begin
                    w_next = DONE;
                end else if ((r_aw_done || m_axi.awready) && (r_w_done || m_axi.wready)) begin
                    w_next = WR_RESP;
                end
            end
            WR_RESP: begin
                w_bready = !w_timeout;
                if (w_timeout || m_axi.bvalid) begin
                    w_next = DONE;
                end
            end
            RD_ADDR: begin
                w_arvalid = !w_timeout;
                if (w_timeout) begin
                    w_next = DONE;
                end else if (m_axi.arready) begin
                    w_next = RD_DATA;
                end
            end
            RD_DATA: begin
                w_rready = !w_timeout;
                if (w_timeout || m_axi.rvalid) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_pready = PSEL && PENABLE && !r_abort;
                w_next   = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_strb    <= '0;
            r_write   <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_abort   <= 1'b0;
            r_slverr  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE) begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
                r_abort   <= 1'b0;
                if (PSEL && !PENABLE) begin
                    r_addr   <= PADDR;
                    r_wdata  <= PWDATA;
                    r_strb   <= PSTRB;
                    r_write  <= PWRITE;
                    r_slverr <= 1'b0;
                    r_rdata  <= '0;
                end
            end else if (!PSEL) begin
                // The master walked away: finish the AXI side, then discard the result.
                r_abort <= 1'b1;
            end
            if (w_awvalid && m_axi.awready) begin
                r_aw_done <= 1'b1;
            end
            if (w_wvalid && m_axi.wready) begin
                r_w_done <= 1'b1;
            end
            if (w_bready && m_axi.bvalid) begin
                r_slverr <= resp_is_err(m_axi.bresp);
            end
            if (w_rready && m_axi.rvalid) begin
                r_rdata  <= m_axi.rdata;
                r_slverr <= resp_is_err(m_axi.rresp);
            end
            if (w_timeout) begin
                r_slverr <= 1'b1;
                r_rdata  <= '0;
            end
        end
    end

    assign m_axi.awvalid = w_awvalid;
    assign m_axi.awaddr  = r_addr;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.wvalid  = w_wvalid;
    assign m_axi.wdata   = r_wdata;
    assign m_axi.wstrb   = r_strb;
    assign m_axi.bready  = w_bready;
    assign m_axi.arvalid = w_arvalid;
    assign m_axi.araddr  = r_addr;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.rready  = w_rready;

    assign PREADY  = w_pready;
    assign PSLVERR = w_pready && r_slverr;
    assign PRDATA  = (w_pready && !r_write) ? r_rdata : 32'h0;
    assign state   = r_state;

endmodule

// File: tb/tb_apb_axi_bridge.sv
// Directed bench for apb_axi_bridge: APB driver, AXI-Lite slave channel tasks, expected-result queue.
module tb_apb_axi_bridge;
    import axi_lite_pkg::*;

    localparam int ADDR_W = 32;
    localparam int TO_CYC = 8;

    logic              aclk = 1'b0;
    logic              areset;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [31:0]       PWDATA;
    logic [3:0]        PSTRB;
    logic [31:0]       PRDATA;
    logic              PREADY;
    logic              PSLVERR;
    logic [2:0]        state;

    axi_lite_if #(.ADDR_W(ADDR_W)) axi ();

    apb_axi_bridge #(
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .aclk    (aclk),
        .areset  (areset),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PSTRB   (PSTRB),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .m_axi   (axi),
        .state   (state)
    );

    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=no finish expected=finish before 200000");
        $fatal(1, "watchdog expired");
    end

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [32:0] exp_q[$];   // {pslverr, prdata} per APB transfer

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bound_fail(input string tag);
        n_assert++;
        n_fail++;
        $error("FAIL %s: observed=no event expected=event within cycle bound", tag);
    endtask

    function automatic logic get_valid(input int ch);
        case (ch)
            0:       return axi.awvalid;
            1:       return axi.wvalid;
            default: return axi.arvalid;
        endcase
    endfunction

    task automatic set_ready(input int ch, input logic v);
        case (ch)
            0:       axi.awready = v;
            1:       axi.wready  = v;
            default: axi.arready = v;
        endcase
    endtask

    // Valid-driven channel (0=aw, 1=w, 2=ar): ready rises after lat valid cycles.
    task automatic vr_chan(input int ch, input int lat, output logic [35:0] payload);
        int n    = 0;
        bit done = 0;
        payload = '0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge aclk);
            if (get_valid(ch)) begin
                if (n >= lat) begin
                    set_ready(ch, 1'b1);
                    case (ch)
                        0:       begin payload = {4'h0, axi.awaddr}; chk("awprot", axi.awprot, 0); end
                        1:       payload = {axi.wstrb, axi.wdata};
                        default: begin payload = {4'h0, axi.araddr}; chk("arprot", axi.arprot, 0); end
                    endcase
                    done = 1;
                end
                n++;
            end else if (n > 0) begin
                chk($sformatf("valid_held_ch%0d", ch), get_valid(ch), 1);
            end
        end
        if (!done) begin
            bound_fail($sformatf("handshake_ch%0d", ch));
        end else begin
            @(posedge aclk);
            #1 set_ready(ch, 1'b0);
            @(negedge aclk);
            chk($sformatf("valid_drop_ch%0d", ch), get_valid(ch), 0);
        end
    endtask

    // Response channel (0=b, 1=r): valid rises after lat cycles of ready.
    task automatic resp_chan(input int ch, input int lat, input axi_resp_t resp, input logic [31:0] data);
        int n    = 0;
        bit done = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge aclk);
            if ((ch == 0) ? axi.bready : axi.rready) begin
                if (n >= lat) begin
                    if (ch == 0) begin
                        axi.bvalid = 1'b1;
                        axi.bresp  = resp;
                    end else begin
                        axi.rvalid = 1'b1;
                        axi.rresp  = resp;
                        axi.rdata  = data;
                    end
                    done = 1;
                end
                n++;
            end
        end
        if (!done) begin
            bound_fail($sformatf("resp_ready_ch%0d", ch));
        end else begin
            @(posedge aclk);
            #1;
            axi.bvalid = 1'b0;
            axi.rvalid = 1'b0;
            @(negedge aclk);
            chk($sformatf("ready_drop_ch%0d", ch), (ch == 0) ? axi.bready : axi.rready, 0);
        end
    endtask

    // Full APB transfer; cycle 0 is setup, cycles counts to the PREADY cycle.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, output int cycles);
        bit          got = 0;
        logic [32:0] e;
        @(posedge aclk);
        #1;
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = addr;
        PWDATA  = wdata;
        PSTRB   = strb;
        @(posedge aclk);
        #1 PENABLE = 1'b1;
        cycles = 1;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge aclk);
            if (PREADY) begin
                got = 1;
            end else begin
                chk("prdata_not_ready", PRDATA, 0);
                chk("pslverr_not_ready", PSLVERR, 0);
                @(posedge aclk);
                #1 cycles++;
            end
        end
        if (!got) begin
            bound_fail("pready");
        end else if (exp_q.size() == 0) begin
            bound_fail("scoreboard_empty");
        end else begin
            e = exp_q.pop_front();
            chk("prdata", PRDATA, e[31:0]);
            chk("pslverr", PSLVERR, e[32]);
        end
        @(posedge aclk);
        #1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        @(negedge aclk);
        chk("pready_one_cycle", PREADY, 0);
    endtask

    logic [35:0] p_aw;
    logic [35:0] p_w;
    logic [35:0] p_ar;
    int          cyc;
    int          pready_cnt;
    bit          found;

    initial begin
        areset      = 1'b1;
        PSEL        = 1'b0;
        PENABLE     = 1'b0;
        PWRITE      = 1'b0;
        PADDR       = '0;
        PWDATA      = '0;
        PSTRB       = '0;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        axi.bresp   = OKAY;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rdata   = '0;
        axi.rresp   = OKAY;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        chk("rst_state", state, IDLE);
        chk("rst_pready", PREADY, 0);
        chk("rst_pslverr", PSLVERR, 0);
        chk("rst_prdata", PRDATA, 0);
        chk("rst_valids", {axi.awvalid, axi.wvalid, axi.arvalid}, 0);
        chk("rst_readies", {axi.bready, axi.rready}, 0);
        areset = 1'b0;
        repeat (2) @(posedge aclk);

        // Write, slave ready at once, OKAY: PREADY at cycle 3.
        exp_q.push_back({1'b0, 32'h0});
        fork
            apb_xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, cyc);
            vr_chan(0, 0, p_aw);
            vr_chan(1, 0, p_w);
            resp_chan(0, 0, OKAY, 32'h0);
        join
        chk("wr1_awaddr", p_aw, 36'h10);
        chk("wr1_wdata_strb", p_w, {4'hF, 32'hDEADBEEF});
        chk("wr1_latency", cyc, 3);

        // Read, arready after 4 valid cycles, OKAY data.
        exp_q.push_back({1'b0, 32'hCAFEF00D});
        fork
            apb_xfer(1'b0, 32'h20, 32'h0, 4'h0, cyc);
            vr_chan(2, 4, p_ar);
            resp_chan(1, 0, OKAY, 32'hCAFEF00D);
        join
        chk("rd1_araddr", p_ar, 36'h20);
        chk("rd1_latency", cyc, 7);
        chk("rd1_state_idle", state, IDLE);

        // Write, awready cycle 1, wready cycle 5, SLVERR.
        exp_q.push_back({1'b1, 32'h0});
        fork
            apb_xfer(1'b1, 32'h44, 32'h0BADF00D, 4'h3, cyc);
            vr_chan(0, 0, p_aw);
            vr_chan(1, 4, p_w);
            resp_chan(0, 0, SLVERR, 32'h0);
        join
        chk("wr2_awaddr", p_aw, 36'h44);
        chk("wr2_wdata_strb", p_w, {4'h3, 32'h0BADF00D});
        chk("wr2_latency", cyc, 7);

        // Read with DECERR: data still returned, error flagged.
        exp_q.push_back({1'b1, 32'h12345678});
        fork
            apb_xfer(1'b0, 32'h88, 32'h0, 4'h0, cyc);
            vr_chan(2, 1, p_ar);
            resp_chan(1, 2, DECERR, 32'h12345678);
        join
        chk("rd2_araddr", p_ar, 36'h88);
        chk("rd2_latency", cyc, 6);

        // Write, w accepted before aw, EXOKAY is not an error.
        exp_q.push_back({1'b0, 32'h0});
        fork
            apb_xfer(1'b1, 32'hC0, 32'h55AA33CC, 4'h9, cyc);
            vr_chan(0, 2, p_aw);
            vr_chan(1, 0, p_w);
            resp_chan(0, 3, EXOKAY, 32'h0);
        join
        chk("wr3_awaddr", p_aw, 36'hC0);
        chk("wr3_wdata_strb", p_w, {4'h9, 32'h55AA33CC});
        chk("wr3_latency", cyc, 8);

        // PSEL dropped mid-write: AXI completes, no PREADY, back to IDLE.
        @(posedge aclk);
        #1;
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b1;
        PADDR   = 32'h50;
        PWDATA  = 32'h01020304;
        PSTRB   = 4'hF;
        @(posedge aclk);
        #1 PENABLE = 1'b1;
        @(posedge aclk);
        #1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        pready_cnt = 0;
        fork
            vr_chan(0, 1, p_aw);
            vr_chan(1, 1, p_w);
            resp_chan(0, 0, OKAY, 32'h0);
            for (int c = 0; c < 12; c++) begin
                @(negedge aclk);
                if (PREADY) pready_cnt++;
            end
        join
        chk("abort_awaddr", p_aw, 36'h50);
        chk("abort_no_pready", pready_cnt, 0);
        chk("abort_state_idle", state, IDLE);

        // Reset while in RD_DATA.
        @(posedge aclk);
        #1;
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = 32'h30;
        @(posedge aclk);
        #1 PENABLE = 1'b1;
        found = 0;
        fork
            vr_chan(2, 0, p_ar);
            for (int c = 0; c < 50 && !found; c++) begin
                @(negedge aclk);
                if (state == RD_DATA) found = 1;
            end
        join
        if (!found) bound_fail("reach_rd_data");
        chk("rst_mid_pre_rready", axi.rready, 1);
        #2 areset = 1'b1;
        #1;
        chk("rst_mid_state", state, IDLE);
        chk("rst_mid_rready", axi.rready, 0);
        chk("rst_mid_arvalid", axi.arvalid, 0);
        chk("rst_mid_pready", PREADY, 0);
        chk("rst_mid_prdata", PRDATA, 0);
        @(posedge aclk);
        #1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        @(negedge aclk);
        areset = 1'b0;
        repeat (2) @(posedge aclk);

        // Recovery read after reset.
        exp_q.push_back({1'b0, 32'hA5A55A5A});
        fork
            apb_xfer(1'b0, 32'h34, 32'h0, 4'h0, cyc);
            vr_chan(2, 0, p_ar);
            resp_chan(1, 0, OKAY, 32'hA5A55A5A);
        join
        chk("rd3_araddr", p_ar, 36'h34);
        chk("rd3_latency", cyc, 3);

`ifdef APB_AXI_BRIDGE_TIMEOUT_EN
        // bvalid never arrives: timeout after TO_CYC busy cycles.
        exp_q.push_back({1'b1, 32'h0});
        fork
            apb_xfer(1'b1, 32'h60, 32'hFFFF0000, 4'hF, cyc);
            vr_chan(0, 0, p_aw);
            vr_chan(1, 0, p_w);
        join
        chk("to_latency", cyc, TO_CYC + 1);
        chk("to_state_idle", state, IDLE);
`endif

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
